auto_guesser: RTL and testbench
===============================

# auto_guesser

Automatic player for the up/down guessing game. It sits on the player side of the guess interface: it drives `user_number` and `guess_trigger` into the guess-input stage and reads the compare stage's `comparison_result` and the game controller's `game_over`. A binary search finds the secret number. This gives a hands-free demo mode and a self-checking stimulus source for the game datapath.

## Interface
- `WIDTH`, 7, bit width of guessed numbers; the search range is 0 to 2^WIDTH-1.
- `SETTLE`, 2, cycles to wait after a trigger pulse before sampling `comparison_result`; legal values are 1 to 15.
- `MAX_GUESSES`, 8, guesses allowed before the search gives up; must be at least WIDTH+1.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a search; sampled only in IDLE, DONE or FAIL.
- `comparison_result`  in  2  00 = guess equals secret, 01 = guess too low (up), 10 = guess too high (down), 11 = invalid.
- `game_over`  in  1  game controller end-of-game flag.
- `user_number`  out  WIDTH  current guess, registered.
- `guess_trigger`  out  1  one-cycle pulse that latches `user_number` into the guess stage, registered.
- `busy`  out  1  high from DRIVE through EVAL.
- `done`  out  1  high in DONE (secret found).
- `fail`  out  1  high in FAIL.
- `found_number`  out  WIDTH  guess that matched; valid while `done` is high.
- `guess_count`  out  4  number of guesses issued in the current or last search.

## Operation
- States are IDLE, DRIVE, WAIT, EVAL, DONE and FAIL.
- Internal registers are `lo` and `hi` (WIDTH bits each), a settle counter and `guess_count`.
- Midpoint: mid = (lo + hi) >> 1, computed at WIDTH+1 bits with no overflow, floor rounding.
- IDLE/DONE/FAIL + `start` → DRIVE:
  - lo = 0, hi = 2^WIDTH-1, `guess_count` = 0.
  - `done`, `fail` and `found_number` are cleared.
- DRIVE (one cycle):
  - `user_number` <= mid.
  - `guess_trigger` = 1 for exactly this cycle.
  - `guess_count` increments.
  - Settle counter loads SETTLE. Next state is WAIT.
- WAIT: the counter decrements each cycle; at 1 → EVAL. `user_number` is held stable from DRIVE through EVAL.
- EVAL (one cycle), sampling `comparison_result`:
  - 00 → DONE; `found_number` <= `user_number`.
  - 01: if mid == 2^WIDTH-1 → FAIL, else lo <= mid+1.
  - 10: if mid == 0 → FAIL, else hi <= mid-1.
  - 11 → FAIL.
- EVAL follow-up after a 01/10 update:
  - If the new lo > hi → FAIL.
  - Else if `guess_count` == MAX_GUESSES → FAIL.
  - Else → DRIVE.
- `game_over` high in EVAL with a result other than 00 → FAIL. `game_over` together with 00 → DONE.
- DONE and FAIL hold their outputs until `start` or `reset`. `start` while `busy` is ignored.

## Timing
- Reset values: `user_number` = 0, `guess_trigger` = 0, `busy` = 0, `done` = 0, `fail` = 0, `found_number` = 0, `guess_count` = 0, state = IDLE.
- Reset asserted mid-search forces `guess_trigger` low immediately, asynchronously, with no further pulse.
- Each guess takes 2+SETTLE cycles (DRIVE, SETTLE×WAIT, EVAL). With defaults that is 4 cycles per guess.
- The cycle after `start` is DRIVE, so `guess_trigger` first rises one cycle after `start` is sampled.
- The `done`/`fail` rising edge is one cycle after the deciding EVAL.
- `guess_trigger` pulses are always separated by at least 1+SETTLE low cycles.
- `start` coincident with `reset`: reset wins.

## Test plan
- Secret 15 (behavioural compare model, SETTLE=2) → guesses 63, 31, 15; `done`=1, `found_number`=15, `guess_count`=3, 12 cycles from DRIVE to DONE.
- Secret 127 → guesses 63, 95, 111, 119, 123, 125, 126, 127; `done`=1, `guess_count`=8. Secret 0 → 7 guesses ending at 0, `done`=1.
- Model always answers 01 (liar) → lo passes 127, `fail`=1 at or before guess 8, no further `guess_trigger` pulses.
- `comparison_result`=11 on the first EVAL → `fail`=1 after 1 guess; then `start` → new search, `fail` cleared, `guess_count` restarts at 1.
- `reset` asserted during WAIT of guess 3 → all outputs at reset values the same cycle; after release `start` gives a full correct search.
- `game_over`=1 with result 10 on guess 2 → `fail`=1; `start` pulsed while `busy` → ignored, `guess_count` continues unchanged.

Source files
------------

// File: rtl/auto_guesser_if.sv
// Guess interface between the automatic player and the game datapath.
//   user_number       : current guess, driven by the player
//   guess_trigger     : one-cycle pulse latching user_number into the guess stage
//   comparison_result : 00 equal, 01 guess too low, 10 guess too high, 11 invalid
//   game_over         : end-of-game flag from the game controller
interface auto_guesser_if #(
    parameter int unsigned WIDTH = 7
);
    logic [WIDTH-1:0] user_number;
    logic             guess_trigger;
    logic [1:0]       comparison_result;
    logic             game_over;

    // Player side
    modport master (
        output user_number,
        output guess_trigger,
        input  comparison_result,
        input  game_over
    );

    // Game side
    modport slave (
        input  user_number,
        input  guess_trigger,
        output comparison_result,
        output game_over
    );
endinterface

// File: rtl/auto_guesser.sv
// Automatic binary-search player for the up/down guessing game.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   start_i         : one-cycle request to begin a search (ignored while busy)
//   gif             : guess interface, player (master) side
//   busy_o          : high from DRIVE through EVAL
//   done_o          : secret found; found_number_o valid
//   fail_o          : search gave up (inconsistent answers, invalid result, game over)
//   found_number_o  : matching guess
//   guess_count_o   : guesses issued in the current or last search
module auto_guesser #(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned MAX_GUESSES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    auto_guesser_if.master     gif,
    output logic               busy_o,
    output logic               done_o,
    output logic               fail_o,
    output logic [WIDTH-1:0]   found_number_o,
    output logic [3:0]         guess_count_o
);

    localparam logic [WIDTH-1:0] MAX_NUM   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] START_MID = MAX_NUM >> 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_EVAL,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [3:0]       cnt_q;
    logic [3:0]       count_q;
    logic [WIDTH-1:0] user_number_q;
    logic             trig_q;
    logic             busy_q, done_q, fail_q;
    logic [WIDTH-1:0] found_q;

    logic [WIDTH-1:0] lo_d, hi_d, mid_d;
    state_t           eval_state_d;

    // Floor midpoint computed one bit wider so lo + hi never wraps
    function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH:1];
    endfunction

    // EVAL decision: narrow the range and pick the follow-up state.
    // user_number_q equals the midpoint issued in the preceding DRIVE.
    always_comb begin
        lo_d         = lo_q;
        hi_d         = hi_q;
        eval_state_d = S_FAIL;
        case (gif.comparison_result)
            2'b00: eval_state_d = S_DONE;
            2'b01: begin
                if (user_number_q != MAX_NUM) begin
                    lo_d         = user_number_q + WIDTH'(1);
                    eval_state_d = S_DRIVE;
                end
            end
            2'b10: begin
                if (user_number_q != '0) begin
                    hi_d         = user_number_q - WIDTH'(1);
                    eval_state_d = S_DRIVE;
                end
            end
            default: eval_state_d = S_FAIL;
        endcase
        if (eval_state_d == S_DRIVE && (lo_d > hi_d || count_q == 4'(MAX_GUESSES)))
            eval_state_d = S_FAIL;
        if (gif.game_over && gif.comparison_result != 2'b00)
            eval_state_d = S_FAIL;
        mid_d = mid_of(lo_d, hi_d);
    end

    // Search FSM; every output is set on the transition into the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lo_q          <= '0;
            hi_q          <= MAX_NUM;
            cnt_q         <= '0;
            count_q       <= '0;
            user_number_q <= '0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            found_q       <= '0;
        end else begin
            trig_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_i) begin
                        lo_q          <= '0;
                        hi_q          <= MAX_NUM;
                        count_q       <= 4'd1;
                        done_q        <= 1'b0;
                        fail_q        <= 1'b0;
                        found_q       <= '0;
                        user_number_q <= START_MID;
                        trig_q        <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    cnt_q   <= 4'(SETTLE);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q <= 4'd1)
                        state_q <= S_EVAL;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                S_EVAL: begin
                    lo_q    <= lo_d;
                    hi_q    <= hi_d;
                    state_q <= eval_state_d;
                    case (eval_state_d)
                        S_DONE: begin
                            done_q  <= 1'b1;
                            found_q <= user_number_q;
                            busy_q  <= 1'b0;
                        end
                        S_DRIVE: begin
                            user_number_q <= mid_d;
                            trig_q        <= 1'b1;
                            count_q       <= count_q + 4'd1;
                        end
                        default: begin
                            fail_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    endcase
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gif.user_number   = user_number_q;
    assign gif.guess_trigger = trig_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign fail_o            = fail_q;
    assign found_number_o    = found_q;
    assign guess_count_o     = count_q;

endmodule

// File: tb/tb_auto_guesser.sv
// Directed bench for auto_guesser with a behavioural compare stage.
module tb_auto_guesser;
    localparam int unsigned WIDTH = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy, done, fail;
    logic [WIDTH-1:0] found;
    logic [3:0]       gcount;

    auto_guesser_if #(.WIDTH(WIDTH)) gif();

    auto_guesser #(.WIDTH(WIDTH), .SETTLE(2), .MAX_GUESSES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start),
        .gif            (gif),
        .busy_o         (busy),
        .done_o         (done),
        .fail_o         (fail),
        .found_number_o (found),
        .guess_count_o  (gcount)
    );

    always #5 clk = ~clk;

    // Compare stage model: mode 0 honest, 1 always "too low", 2 always invalid
    int               mode = 0;
    logic [WIDTH-1:0] secret = '0;
    logic [WIDTH-1:0] latched = '0;
    logic             go = 1'b0;
    logic [1:0]       cr;

    always @(posedge clk) if (gif.guess_trigger) latched <= gif.user_number;

    always_comb begin
        if (mode == 1)             cr = 2'b01;
        else if (mode == 2)        cr = 2'b11;
        else if (latched == secret) cr = 2'b00;
        else if (latched < secret)  cr = 2'b01;
        else                        cr = 2'b10;
    end
    assign gif.comparison_result = cr;
    assign gif.game_over         = go;

    // Trigger log and pulse-spacing monitor
    logic [WIDTH-1:0] glog[$];
    int cyc = 0, last_trig = -100, gap_viol = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (gif.guess_trigger) begin
            glog.push_back(gif.user_number);
            if (cyc - last_trig < 4) gap_viol = gap_viol + 1;
            last_trig = cyc;
        end
    end

    int nvec = 0, nbad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cycles);
        cycles = 0;
        while (!(done || fail) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("end_reached", 32'(done || fail), 1);
    endtask

    task automatic wait_trig(input int n, input int budget);
        int k = 0;
        while (glog.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("trig_reached", 32'(glog.size() >= n), 1);
    endtask

    task automatic check_guesses(input int base, input int e[$]);
        check("guess_total", 32'(glog.size() - base), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            logic [31:0] obs;
            obs = (base + i < glog.size()) ? 32'(glog[base + i]) : 32'hFFFF;
            check($sformatf("guess[%0d]", i), obs, 32'(e[i]));
        end
    endtask

    initial begin
        int cycles, base, n0;
        int e[$];

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_user_number", 32'(gif.user_number), 0);
        check("rst_trigger", 32'(gif.guess_trigger), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_found", 32'(found), 0);
        check("rst_count", 32'(gcount), 0);
        reset = 1'b0;

        // Secret 15: three guesses, 12 cycles from DRIVE to DONE
        secret = 7'd15; base = glog.size();
        pulse_start();
        check("s15_first_trigger", 32'(gif.guess_trigger), 1);
        check("s15_busy", 32'(busy), 1);
        wait_end(200, cycles);
        check("s15_latency", 32'(cycles), 12);
        check("s15_done", 32'(done), 1);
        check("s15_fail", 32'(fail), 0);
        check("s15_found", 32'(found), 15);
        check("s15_count", 32'(gcount), 3);
        check("s15_busy_low", 32'(busy), 0);
        e = '{63, 31, 15};
        check_guesses(base, e);

        // Secret 127: upper boundary, exactly MAX_GUESSES guesses
        secret = 7'd127; base = glog.size();
        pulse_start();
        wait_end(200, cycles);
        check("s127_done", 32'(done), 1);
        check("s127_found", 32'(found), 127);
        check("s127_count", 32'(gcount), 8);
        e = '{63, 95, 111, 119, 123, 125, 126, 127};
        check_guesses(base, e);

        // Secret 0: lower boundary
        secret = 7'd0; base = glog.size();
        pulse_start();
        wait_end(200, cycles);
        check("s0_done", 32'(done), 1);
        check("s0_found", 32'(found), 0);
        check("s0_count", 32'(gcount), 7);
        e = '{63, 31, 15, 7, 3, 1, 0};
        check_guesses(base, e);

        // Liar answering "too low" forever
        mode = 1; base = glog.size();
        pulse_start();
        check("liar_done_cleared", 32'(done), 0);
        wait_end(200, cycles);
        check("liar_fail", 32'(fail), 1);
        check("liar_done", 32'(done), 0);
        check("liar_count", 32'(gcount), 8);
        n0 = glog.size();
        repeat (12) @(negedge clk);
        check("liar_no_more_triggers", 32'(glog.size()), 32'(n0));
        check("liar_fail_held", 32'(fail), 1);
        e = '{63, 95, 111, 119, 123, 125, 126, 127};
        check_guesses(base, e);

        // Invalid result on first EVAL, then restart
        mode = 2;
        pulse_start();
        wait_end(200, cycles);
        check("inv_fail", 32'(fail), 1);
        check("inv_count", 32'(gcount), 1);
        mode = 0; secret = 7'd15;
        pulse_start();
        check("inv_restart_fail_clr", 32'(fail), 0);
        check("inv_restart_count", 32'(gcount), 1);
        wait_end(200, cycles);
        check("inv_restart_done", 32'(done), 1);
        check("inv_restart_found", 32'(found), 15);

        // Reset during WAIT of guess 3
        secret = 7'd100; base = glog.size();
        pulse_start();
        wait_trig(base + 3, 100);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_trigger", 32'(gif.guess_trigger), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_user_number", 32'(gif.user_number), 0);
        check("arst_count", 32'(gcount), 0);
        n0 = glog.size();
        repeat (6) @(negedge clk);
        check("arst_no_triggers", 32'(glog.size()), 32'(n0));
        reset = 1'b0;
        base = glog.size();
        pulse_start();
        wait_end(200, cycles);
        check("arst_search_done", 32'(done), 1);
        check("arst_search_found", 32'(found), 100);
        check("arst_search_count", 32'(gcount), 7);
        e = '{63, 95, 111, 103, 99, 101, 100};
        check_guesses(base, e);

        // game_over with "too high" on guess 2; start while busy ignored
        secret = 7'd15; base = glog.size();
        pulse_start();
        pulse_start();
        check("busy_start_ignored_count", 32'(gcount), 1);
        check("busy_start_still_busy", 32'(busy), 1);
        wait_trig(base + 2, 100);
        go = 1'b1;
        wait_end(200, cycles);
        check("go_fail", 32'(fail), 1);
        check("go_done", 32'(done), 0);
        check("go_count", 32'(gcount), 2);
        go = 1'b0;
        e = '{63, 31};
        check_guesses(base, e);

        check("trigger_spacing_violations", 32'(gap_viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
